// File: rtl/des_pipe_pkg.sv
// Shared widths and word-lane ordering for the DES output serializer.
// Words leave a 64-bit block low half first, matching the engine's packing.
package des_pipe_pkg;

    localparam int BLK_W         = 64;
    localparam int WORD_W        = 16;
    localparam int WORDS_PER_BLK = 4;
    localparam int IDX_W         = 2;

    function automatic logic [WORD_W-1:0] word_lane(
        input logic [BLK_W-1:0] blk,
        input logic [IDX_W-1:0] idx
    );
        logic [WORD_W-1:0] w;
        w = '0;
        unique case (idx)
            2'd0: w = blk[15:0];
            2'd1: w = blk[31:16];
            2'd2: w = blk[47:32];
            2'd3: w = blk[63:48];
        endcase
        return w;
    endfunction

endpackage

// File: rtl/des_pipe_serializer_if.sv
// Block-in / word-out bundle between the DES engine, the pipe endpoint
// and the serializer.
interface des_pipe_serializer_if
    import des_pipe_pkg::*;
#(
    parameter int DEPTH = 4
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic [BLK_W-1:0]  blk_data;
    logic              blk_valid;
    logic              blk_ready;
    logic              pipe_read;
    logic [WORD_W-1:0] pipe_data;
    logic              frame_clear;
    logic              frame_done;
    logic              underflow;
    logic [LW-1:0]     level;

    modport master (
        output blk_data, blk_valid, pipe_read, frame_clear,
        input  blk_ready, pipe_data, frame_done, underflow, level
    );

    modport slave (
        input  blk_data, blk_valid, pipe_read, frame_clear,
        output blk_ready, pipe_data, frame_done, underflow, level
    );

endinterface

// File: rtl/des_block_fifo.sv
// DEPTH x 64-bit block store with wrapping pointers and synchronous flush.
// Push into full or pop from empty is ignored, so level stays in range.
module des_block_fifo
    import des_pipe_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [BLK_W-1:0] din,
    output logic [BLK_W-1:0] head,
    output logic [LW-1:0]    level,
    output logic             full,
    output logic             empty
);

    logic [BLK_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == LW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (do_pop && !do_push)
                count <= count - 1'b1;
        end
    end

    // Storage needs no reset: head is never observed while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    assign head  = mem[rd_ptr];
    assign level = count;

endmodule

// File: rtl/des_pipe_serializer.sv
// Serializes buffered 64-bit DES result blocks into 16-bit pipe words,
// counting retired blocks into frames for the host trigger logic.
module des_pipe_serializer
    import des_pipe_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int FRAME_BLOCKS = 256
) (
    input logic                   ti_clk,
    input logic                   reset,
    des_pipe_serializer_if.slave  bus
);

    localparam int LW = $clog2(DEPTH) + 1;
    localparam int CW = $clog2(FRAME_BLOCKS + 1);

    logic             en_q;
    logic [IDX_W-1:0] widx;
    logic [CW-1:0]    blk_cnt;
    logic             done_q;
    logic             uflow_q;
    logic [BLK_W-1:0] head;
    logic [LW-1:0]    lvl;
    logic             full;
    logic             empty;
    logic             push;
    logic             rd_ok;
    logic             retire;
    logic             pop;

    assign push   = bus.blk_valid & bus.blk_ready & ~bus.frame_clear;
    assign rd_ok  = bus.pipe_read & ~empty;
    assign retire = rd_ok & (widx == IDX_W'(WORDS_PER_BLK - 1));
    assign pop    = retire & ~bus.frame_clear;

    des_block_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (ti_clk),
        .rst   (reset),
        .flush (bus.frame_clear),
        .push  (push),
        .pop   (pop),
        .din   (bus.blk_data),
        .head  (head),
        .level (lvl),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge ti_clk or posedge reset) begin
        if (reset) begin
            en_q    <= 1'b0;
            widx    <= '0;
            blk_cnt <= '0;
            done_q  <= 1'b0;
            uflow_q <= 1'b0;
        end else begin
            en_q   <= 1'b1;
            done_q <= 1'b0;
            if (bus.frame_clear) begin
                widx    <= '0;
                blk_cnt <= '0;
                uflow_q <= 1'b0;
            end else begin
                if (rd_ok)
                    widx <= widx + 1'b1;
                if (bus.pipe_read && empty)
                    uflow_q <= 1'b1;
                if (retire) begin
                    if (blk_cnt == CW'(FRAME_BLOCKS - 1)) begin
                        blk_cnt <= '0;
                        done_q  <= 1'b1;
                    end else begin
                        blk_cnt <= blk_cnt + 1'b1;
                    end
                end
            end
        end
    end

    // Ready comes only from registers so the engine sees no input path.
    assign bus.blk_ready  = en_q & ~full;
    assign bus.pipe_data  = empty ? '0 : word_lane(head, widx);
    assign bus.level      = lvl;
    assign bus.frame_done = done_q;
    assign bus.underflow  = uflow_q;

endmodule

// File: tb/tb_des_pipe_serializer.sv
// Bench for des_pipe_serializer: vector table plus scoreboarded sequences.
module tb_des_pipe_serializer;
    import des_pipe_pkg::*;

    localparam int DEPTH = 4;
    localparam int FB    = 256;

    typedef struct packed {
        logic [63:0]      blk;
        logic [3:0][15:0] w;
    } vec_t;

    logic ti_clk = 1'b0;
    logic reset  = 1'b1;
    always #5 ti_clk = ~ti_clk;

    des_pipe_serializer_if #(.DEPTH(DEPTH)) bus ();

    des_pipe_serializer #(
        .DEPTH        (DEPTH),
        .FRAME_BLOCKS (FB)
    ) dut (
        .ti_clk (ti_clk),
        .reset  (reset),
        .bus    (bus)
    );

    int total = 0;
    int bad   = 0;
    logic [15:0] sb [$];
    vec_t tbl [3];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        total++;
        bad++;
        $display("FAIL %s: bound expired or model out of data", nm);
    endtask

    task automatic step;
        @(posedge ti_clk);
        #1;
    endtask

    task automatic add_blk(input logic [63:0] d);
        for (int i = 0; i < 4; i++) sb.push_back(d[i*16 +: 16]);
    endtask

    task automatic push_blk(input logic [63:0] d);
        int n;
        n = 0;
        bus.blk_valid = 1'b1;
        bus.blk_data  = d;
        while (!bus.blk_ready && n < 50) begin
            step;
            n++;
        end
        if (!bus.blk_ready) fail("push_timeout");
        else begin
            step;
            add_blk(d);
        end
        bus.blk_valid = 1'b0;
    endtask

    task automatic rd_word(input string nm);
        if (sb.size() == 0) fail({nm, "_model_empty"});
        else chk(nm, 64'(bus.pipe_data), 64'(sb.pop_front()));
        bus.pipe_read = 1'b1;
        step;
        bus.pipe_read = 1'b0;
    endtask

    initial begin
        int pushed, reads, pulses, cyc;
        logic do_push, do_rd;
        logic [63:0] d;

        tbl[0] = '{64'h0123_4567_89AB_CDEF,
                   {16'h0123, 16'h4567, 16'h89AB, 16'hCDEF}};
        tbl[1] = '{64'hFFFF_0000_A5A5_5A5A,
                   {16'hFFFF, 16'h0000, 16'hA5A5, 16'h5A5A}};
        tbl[2] = '{64'h8000_0001_7FFF_FFFE,
                   {16'h8000, 16'h0001, 16'h7FFF, 16'hFFFE}};

        bus.blk_data    = '0;
        bus.blk_valid   = 1'b0;
        bus.pipe_read   = 1'b0;
        bus.frame_clear = 1'b0;

        // reset values
        step;
        step;
        chk("rst_ready", 64'(bus.blk_ready), 64'd0);
        chk("rst_data", 64'(bus.pipe_data), 64'd0);
        chk("rst_done", 64'(bus.frame_done), 64'd0);
        chk("rst_uflow", 64'(bus.underflow), 64'd0);
        chk("rst_level", 64'(bus.level), 64'd0);
        reset = 1'b0;
        step;
        chk("ready_after_rst", 64'(bus.blk_ready), 64'd1);

        // table: one block in, four words out in lane order
        for (int v = 0; v < 3; v++) begin
            push_blk(tbl[v].blk);
            chk("tbl_level1", 64'(bus.level), 64'd1);
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("tbl%0d_w%0d", v, i),
                    64'(bus.pipe_data), 64'(tbl[v].w[i]));
                rd_word("tbl_sb");
            end
            chk("tbl_level0", 64'(bus.level), 64'd0);
        end

        // fill to DEPTH with valid held, then free one slot
        bus.blk_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            d = {16'hF000 + 16'(i), 16'h0C00 + 16'(i),
                 16'h00B0 + 16'(i), 16'h000A + 16'(i)};
            bus.blk_data = d;
            if (!bus.blk_ready) fail("fill_ready");
            else begin
                step;
                add_blk(d);
            end
        end
        chk("full_level", 64'(bus.level), 64'd4);
        chk("full_ready", 64'(bus.blk_ready), 64'd0);
        d = 64'h5555_6666_7777_8888;
        bus.blk_data = d;
        for (int i = 0; i < 4; i++) rd_word("full_rd");
        chk("no_bypass_level", 64'(bus.level), 64'd3);
        chk("ready_again", 64'(bus.blk_ready), 64'd1);
        step;
        add_blk(d);
        bus.blk_valid = 1'b0;
        chk("refill_level", 64'(bus.level), 64'd4);
        for (int i = 0; i < 16; i++) rd_word("full_drain");
        chk("drain_level", 64'(bus.level), 64'd0);

        // two frames at full read rate
        bus.frame_clear = 1'b1;
        step;
        bus.frame_clear = 1'b0;
        pushed = 0;
        reads  = 0;
        pulses = 0;
        cyc    = 0;
        while ((pushed < 2 * FB || sb.size() > 0) && cyc < 6000) begin
            do_push = (pushed < 2 * FB) && bus.blk_ready;
            do_rd   = (sb.size() > 0);
            d = {16'(pushed*4+3), 16'(pushed*4+2),
                 16'(pushed*4+1), 16'(pushed*4)};
            bus.blk_valid = do_push;
            bus.blk_data  = d;
            if (do_rd) chk("stream", 64'(bus.pipe_data), 64'(sb.pop_front()));
            bus.pipe_read = do_rd;
            step;
            if (do_push) begin
                add_blk(d);
                pushed++;
            end
            if (do_rd) reads++;
            if (bus.frame_done) begin
                pulses++;
                chk("frame_done_pos", 64'(reads), 64'(pulses * 4 * FB));
            end
            cyc++;
        end
        bus.blk_valid = 1'b0;
        bus.pipe_read = 1'b0;
        if (cyc >= 6000) fail("stream_timeout");
        chk("frame_pulses", 64'(pulses), 64'd2);
        chk("stream_words", 64'(reads), 64'(8 * FB));
        chk("stream_uflow", 64'(bus.underflow), 64'd0);

        // underflow is sticky until frame_clear
        chk("empty_data", 64'(bus.pipe_data), 64'd0);
        bus.pipe_read = 1'b1;
        step;
        bus.pipe_read = 1'b0;
        chk("uflow_set", 64'(bus.underflow), 64'd1);
        chk("uflow_level", 64'(bus.level), 64'd0);
        push_blk(tbl[1].blk);
        for (int i = 0; i < 4; i++) rd_word("uflow_rd");
        chk("uflow_sticky", 64'(bus.underflow), 64'd1);
        push_blk(tbl[2].blk);
        bus.frame_clear = 1'b1;
        bus.blk_valid   = 1'b1;
        bus.blk_data    = tbl[0].blk;
        bus.pipe_read   = 1'b1;
        step;
        bus.frame_clear = 1'b0;
        bus.blk_valid   = 1'b0;
        bus.pipe_read   = 1'b0;
        sb.delete();
        chk("clr_level", 64'(bus.level), 64'd0);
        chk("clr_uflow", 64'(bus.underflow), 64'd0);
        chk("clr_data", 64'(bus.pipe_data), 64'd0);

        // push and retire on the same edge at level 2
        push_blk(tbl[0].blk);
        push_blk(tbl[1].blk);
        for (int i = 0; i < 3; i++) rd_word("sim_rd");
        chk("sim_pre_level", 64'(bus.level), 64'd2);
        bus.blk_valid = 1'b1;
        bus.blk_data  = tbl[2].blk;
        if (sb.size() == 0) fail("sim_model_empty");
        else chk("sim_w3", 64'(bus.pipe_data), 64'(sb.pop_front()));
        bus.pipe_read = 1'b1;
        step;
        add_blk(tbl[2].blk);
        bus.blk_valid = 1'b0;
        bus.pipe_read = 1'b0;
        chk("sim_level", 64'(bus.level), 64'd2);
        for (int i = 0; i < 8; i++) rd_word("sim_drain");
        chk("sim_end_level", 64'(bus.level), 64'd0);

        // asynchronous reset after 2.5 blocks read
        bus.pipe_read = 1'b1;
        step;
        bus.pipe_read = 1'b0;
        push_blk(tbl[0].blk);
        push_blk(tbl[1].blk);
        push_blk(tbl[2].blk);
        for (int i = 0; i < 10; i++) rd_word("mid_rd");
        chk("mid_level", 64'(bus.level), 64'd1);
        chk("mid_uflow", 64'(bus.underflow), 64'd1);
        #3 reset = 1'b1;
        #1;
        chk("arst_level", 64'(bus.level), 64'd0);
        chk("arst_ready", 64'(bus.blk_ready), 64'd0);
        chk("arst_data", 64'(bus.pipe_data), 64'd0);
        chk("arst_uflow", 64'(bus.underflow), 64'd0);
        chk("arst_done", 64'(bus.frame_done), 64'd0);
        sb.delete();
        step;
        step;
        reset = 1'b0;
        step;
        chk("rel_ready", 64'(bus.blk_ready), 64'd1);
        push_blk(tbl[2].blk);
        chk("rel_word0", 64'(bus.pipe_data), 64'(tbl[2].w[0]));
        for (int i = 0; i < 4; i++) rd_word("rel_rd");
        chk("rel_level", 64'(bus.level), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/des_pipe_serializer.md
# des_pipe_serializer

Output-side companion to the block DES engine. It accepts 64-bit DES result blocks from the engine over a valid/ready handshake and buffers them in a small block FIFO. It serializes them into 16-bit words for an okPipeOut endpoint, signalling frame completion to the host-facing TriggerOut logic. It replaces the output block RAM and its 18/36-bit port pair, so results stream to the host while the engine keeps running instead of waiting for a full 2048-byte buffer.

## Interface
- DEPTH, 4: FIFO capacity in 64-bit blocks; power of two, at least 2.
- FRAME_BLOCKS, 256: blocks per frame (256 × 8 bytes = 2048 bytes); at least 1.
- ti_clk  in  1  host-interface clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high; one clock, reset is asynchronous and active-high.
- blk_data  in  64  DES result block.
- blk_valid  in  1  blk_data valid.
- blk_ready  out  1  block will be accepted this cycle.
- pipe_read  in  1  okPipeOut ep_read; consume current word.
- pipe_data  out  16  okPipeOut ep_datain; current head word.
- frame_clear  in  1  synchronous flush, from a TriggerIn bit.
- frame_done  out  1  one-cycle pulse when the last word of a frame is read.
- underflow  out  1  sticky; set by a pipe_read while empty.
- level  out  clog2(DEPTH)+1  blocks currently held, including a partially read head block.

## Operation
- Push:
  - A block is accepted on an edge where blk_valid && blk_ready.
  - blk_ready = (level < DEPTH), decoded from registered state only.
  - There is no bypass: a full FIFO does not accept a block in the same cycle it frees a slot.
- Word order within a block, host byte stream order:
  - word0 = blk_data[15:0]
  - word1 = [31:16]
  - word2 = [47:32]
  - word3 = [63:48]
  - This matches low-32-first packing of the DES result.
- Pop:
  - A 2-bit word index selects pipe_data from the head block.
  - A pipe_read while not empty advances the index.
  - A read at index 3 retires the head block, decrements level and sets the index to 0.
- Empty:
  - pipe_data = 16'h0000.
  - A pipe_read while empty sets underflow and advances nothing.
- Simultaneous push and head-block retire: level stays unchanged and both take effect.
- Frame counting:
  - A block counter counts retired blocks.
  - On the retire that makes the count FRAME_BLOCKS, frame_done pulses and the counter wraps to 0.
- frame_clear:
  - Empties the FIFO and zeroes the word index, block counter and underflow.
  - Has priority over a push or pop in the same cycle; those are dropped, and no frame_done is generated.
- Pointers wrap modulo DEPTH.
- level saturates structurally: it never exceeds DEPTH and never goes below 0.

## Timing
- Values while reset is asserted, all held until the first edge after release:
  - blk_ready=0
  - pipe_data=0
  - frame_done=0
  - underflow=0
  - level=0
  - word index=0
  - block count=0
- blk_ready is registered: 1 from the first edge after reset release.
- A reset asserted mid-frame discards all buffered data immediately.
- Push to output latency:
  - A block accepted at edge N into an empty FIFO drives word0 on pipe_data after edge N.
  - level reads 1 after edge N.
- Read:
  - With pipe_read high in the cycle before edge M, pipe_data shows the next word after edge M.
  - Back-to-back reads every cycle are supported at full rate.
- frame_done is registered and is high for exactly the cycle after the retiring edge.
- underflow sets on the edge of the offending read.
- pipe_data, blk_ready, level, frame_done and underflow have no combinational path from any input.

## Structure
- Package des_pipe_pkg holds:
  - BLK_W=64
  - WORD_W=16
  - WORDS_PER_BLK=4
  - the word-lane ordering function (index to bit slice)
- Sub-module des_block_fifo holds the storage:
  - a DEPTH×64 register array
  - write and read pointers
  - level, full and empty
  - a synchronous flush input
- The top of this block contains only the word index, frame counter, underflow flag and handshake glue.

## Test plan
- Reset, then push 64'h0123_4567_89AB_CDEF, then 4 reads → pipe_data 16'hCDEF, 89AB, 4567, 0123; level returns to 0.
- Hold blk_valid with no reads for DEPTH=4 pushes → blk_ready drops after the 4th acceptance and level=4. Then 4 reads → blk_ready=1 the next cycle, and a block waiting on blk_valid is accepted on the next edge.
- With 256 blocks streamed and pipe_read high every cycle → 1024 words in order; exactly one frame_done, in the cycle after the 1024th read. The next 256 blocks produce a second pulse, confirming the wrap.
- pipe_read while empty → pipe_data=0, underflow=1 and sticky across later valid reads; frame_clear → underflow=0.
- Push and retire on the same edge at level=2 → level stays 2 and no word is lost or duplicated. Check the output stream against a reference model.
- Assert reset after 2.5 blocks have been read → all outputs reach reset values asynchronously. After release, a new block is read from its word0.
